ring_drain_monitor: RTL

- Sits between the PE/ring-node array and the broadcast controller.
- Tracks per-cell reference-force writeback issue and counts drain cycles after all cells have issued.
- Counts ring packets in flight and declares the end-of-iteration force flush.
- Produces all_ref_wb_issued, drain_counter and all_force_wr_issued for the broadcast controller.

---
 rtl/ring_drain_monitor.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/ring_drain_monitor.sv
// ring_drain_monitor
// Sits between the PE/ring-node array and the broadcast controller. It tracks
// which cells have issued their reference-force writeback for the current ref,
// counts drain cycles once every cell has issued, keeps a saturating count of
// ring packets in flight, and declares the end-of-iteration force flush once
// the ring has been quiet for FLUSH_CYCLES cycles.
//
// state | meaning
// IDLE  | waiting for the first iter_start after reset
// RUN   | iteration in progress, waiting for the flush preconditions
// FLUSH | ring quiet, counting flush_cnt up to FLUSH_CYCLES-1
// DONE  | force traffic fully flushed, all_force_wr_issued_o held high
module ring_drain_monitor #(
  parameter int NUM_CELLS    = 64,
  parameter int FLUSH_CYCLES = NUM_CELLS,
  parameter int MAX_INFLIGHT = 4*NUM_CELLS
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               iter_start_i,
  input  logic                               goto_next_ref_i,
  input  logic [NUM_CELLS-1:0]               ref_wb_pulse_i,
  input  logic [NUM_CELLS-1:0]               ring_inject_i,
  input  logic [NUM_CELLS-1:0]               ring_eject_i,
  input  logic                               all_reading_done_i,
  output logic                               all_ref_wb_issued_o,
  output logic [$clog2(NUM_CELLS):0]         drain_counter_o,
  output logic                               all_force_wr_issued_o,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0]  inflight_count_o,
  output logic                               count_err_o
);

  localparam int DW = $clog2(NUM_CELLS) + 1;
  localparam int IW = $clog2(MAX_INFLIGHT + 1);
  localparam int PW = $clog2(NUM_CELLS + 1);
  localparam int SW = ((IW > PW) ? IW : PW) + 2;
  localparam int FW = $clog2(FLUSH_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t                state_q;
  logic [FW-1:0]         flush_cnt_q;
  logic                  done_q;
  logic [NUM_CELLS-1:0]  wb_seen_q, wb_seen_d;
  logic                  all_ref_q;
  logic [DW-1:0]         drain_q;
  logic [IW-1:0]         inflight_q, inflight_d;
  logic                  count_err_q, count_err_d;
  logic                  clear_ref;
  logic signed [SW-1:0]  inflight_sum;

  function automatic logic [PW-1:0] popcount(input logic [NUM_CELLS-1:0] v);
    logic [PW-1:0] c;
    c = '0;
    for (int i = 0; i < NUM_CELLS; i++) c = c + PW'(v[i]);
    return c;
  endfunction

  assign clear_ref = goto_next_ref_i | iter_start_i;

  // A clear and a same-cycle pulse: the pulse belongs to the new ref, so clear first.
  always_comb begin
    wb_seen_d = (clear_ref ? '0 : wb_seen_q) | ref_wb_pulse_i;
  end

  // Signed full-width in-flight update with clamping at both ends.
  always_comb begin
    inflight_sum = $signed(SW'(inflight_q)) + $signed(SW'(popcount(ring_inject_i)))
                   - $signed(SW'(popcount(ring_eject_i)));
    inflight_d   = inflight_sum[IW-1:0];
    count_err_d  = count_err_q;
    if (inflight_sum < 0) begin
      inflight_d  = '0;
      count_err_d = 1'b1;
    end else if (inflight_sum > $signed(SW'(MAX_INFLIGHT))) begin
      inflight_d  = IW'(MAX_INFLIGHT);
      count_err_d = 1'b1;
    end
  end

  // Writeback tracking and the saturating drain counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_seen_q <= '0;
      all_ref_q <= 1'b0;
      drain_q   <= '0;
    end else begin
      wb_seen_q <= wb_seen_d;
      all_ref_q <= &wb_seen_d;
      if (clear_ref)
        drain_q <= '0;
      else if (all_ref_q && (drain_q != DW'(NUM_CELLS)))
        drain_q <= drain_q + DW'(1);
    end
  end

  // In-flight packet counter; survives iter_start, only rst clears it and the error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q  <= '0;
      count_err_q <= 1'b0;
    end else begin
      inflight_q  <= inflight_d;
      count_err_q <= count_err_d;
    end
  end

  // Iteration flush FSM; iter_start overrides every state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      flush_cnt_q <= '0;
      done_q      <= 1'b0;
    end else if (iter_start_i) begin
      state_q     <= RUN;
      flush_cnt_q <= '0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
        end
        RUN: begin
          if (all_reading_done_i && all_ref_q && (inflight_q == '0) && (ring_inject_i == '0)) begin
            state_q     <= FLUSH;
            flush_cnt_q <= '0;
          end
        end
        FLUSH: begin
          if ((ring_inject_i != '0) || (inflight_q != '0) || !all_reading_done_i) begin
            state_q <= RUN;
          end else if (flush_cnt_q == FW'(FLUSH_CYCLES - 1)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            flush_cnt_q <= flush_cnt_q + FW'(1);
          end
        end
        DONE: begin
          done_q <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign all_ref_wb_issued_o   = all_ref_q;
  assign drain_counter_o       = drain_q;
  assign all_force_wr_issued_o = done_q;
  assign inflight_count_o      = inflight_q;
  assign count_err_o           = count_err_q;

endmodule
